// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: payload width, FIFO entry layout and entry pack/unpack helpers.
// The receiver, RX FIFO and TX FIFO all agree on the {break, data} entry format defined here.
package uart_rx_fifo_pkg;

    localparam int UART_PAYLOAD_BITS    = 8;
    localparam int UART_FIFO_ENTRY_W    = 9;
    localparam int UART_ENTRY_DATA_LSB  = 0;
    localparam int UART_ENTRY_BREAK_BIT = 8;

    function automatic logic [UART_FIFO_ENTRY_W-1:0] uart_pack_entry(
        input logic                         brk,
        input logic [UART_PAYLOAD_BITS-1:0] data
    );
        logic [UART_FIFO_ENTRY_W-1:0] e;
        e                                            = '0;
        e[UART_ENTRY_BREAK_BIT]                      = brk;
        e[UART_ENTRY_DATA_LSB +: UART_PAYLOAD_BITS]  = data;
        return e;
    endfunction

    function automatic logic [UART_PAYLOAD_BITS-1:0] uart_entry_data(
        input logic [UART_FIFO_ENTRY_W-1:0] e
    );
        return e[UART_ENTRY_DATA_LSB +: UART_PAYLOAD_BITS];
    endfunction

    function automatic logic uart_entry_break(
        input logic [UART_FIFO_ENTRY_W-1:0] e
    );
        return e[UART_ENTRY_BREAK_BIT];
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array, one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; the owning FIFO masks reads while empty.
module uart_fifo_mem #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 9,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: captures {break, data} pulses, show-ahead read port,
// fill level, threshold interrupt and sticky overrun flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         rx_valid,
    input  logic [UART_PAYLOAD_BITS-1:0] rx_data,
    input  logic                         rx_break,
    input  logic                         flush,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [UART_PAYLOAD_BITS-1:0] rd_data,
    output logic                         rd_break,
    output logic [LVL_W-1:0]             level,
    input  logic [LVL_W-1:0]             thresh,
    output logic                         irq_thresh,
    output logic                         full,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int AW = LVL_W - 1;

    logic [LVL_W-1:0]             wptr_q, wptr_d;
    logic [LVL_W-1:0]             rptr_q, rptr_d;
    logic                         overrun_q, overrun_d;
    logic                         empty;
    logic                         push, pop, ovr_evt;
    logic [UART_FIFO_ENTRY_W-1:0] wr_entry;
    logic [UART_FIFO_ENTRY_W-1:0] rd_entry;

    // Status is a pure function of the registered pointers, so it never sees rx_valid or rd_ready.
    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign level      = wptr_q - rptr_q;
    assign rd_valid   = !empty;
    assign irq_thresh = (thresh != '0) && (level >= thresh);
    assign overrun    = overrun_q;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept the incoming byte.
    assign pop     = rd_valid && rd_ready && !flush;
    assign push    = rx_valid && (!full || pop) && !flush;
    assign ovr_evt = rx_valid && full && !pop && !flush;

    assign wr_entry = uart_pack_entry(rx_break, rx_data);

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (UART_FIFO_ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

    assign rd_data  = rd_valid ? uart_entry_data(rd_entry)  : '0;
    assign rd_break = rd_valid ? uart_entry_break(rd_entry) : 1'b0;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        overrun_d = overrun_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + LVL_W'(1);
            if (pop)  rptr_d = rptr_q + LVL_W'(1);
        end
        // A new drop outranks a clear arriving in the same cycle.
        if (ovr_evt) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one task per scenario with hand-computed expected values.
module tb_uart_rx_fifo;

    logic       clk;
    logic       resetn;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_break;
    logic       flush;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_break;
    logic [4:0] level;
    logic [4:0] thresh;
    logic       irq_thresh;
    logic       full;
    logic       overrun;
    logic       overrun_clr;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_break    (rx_break),
        .flush       (flush),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_break    (rd_break),
        .level       (level),
        .thresh      (thresh),
        .irq_thresh  (irq_thresh),
        .full        (full),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic b);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_break = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_break = 1'b0;
    endtask

    task automatic fill16(input logic [7:0] base);
        for (int i = 0; i < 16; i++) push_byte(base + 8'(i), 1'b0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        checks++; if (level !== 5'd0)      begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0b exp=0", irq_thresh); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        checks++; if (rd_data !== 8'h00)   begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if (rd_break !== 1'b0)   begin errors++; $display("FAIL reset_rd_break got=%0b exp=0", rd_break); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        push_byte(8'h41, 1'b0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid got=%0b exp=1", rd_valid); end
        checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL basic_first_data got=%h exp=41", rd_data); end
        push_byte(8'h42, 1'b0);
        push_byte(8'h43, 1'b0);
        checks++; if (level !== 5'd3)    begin errors++; $display("FAIL basic_level got=%0d exp=3", level); end
        checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL basic_head got=%h exp=41", rd_data); end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h41 + 8'(i)) begin
                errors++; $display("FAIL basic_pop%0d got=%h/%0b exp=%h/1", i, rd_data, rd_valid, 8'h41 + 8'(i));
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drained_valid got=%0b exp=0", rd_valid); end
        checks++; if (level !== 5'd0)    begin errors++; $display("FAIL basic_drained_level got=%0d exp=0", level); end
    endtask

    task automatic test_overrun();
        fill16(8'h00);
        checks++; if (full !== 1'b1)    begin errors++; $display("FAIL ovr_full got=%0b exp=1", full); end
        checks++; if (level !== 5'd16)  begin errors++; $display("FAIL ovr_level got=%0d exp=16", level); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%0b exp=0", overrun); end
        push_byte(8'hAA, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
        checks++; if (level !== 5'd16)  begin errors++; $display("FAIL ovr_level_after got=%0d exp=16", level); end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                errors++; $display("FAIL ovr_pop%0d got=%h/%0b exp=%h/1", i, rd_data, rd_valid, 8'(i));
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_no_AA got=%0b data=%h exp=0", rd_valid, rd_data); end
        checks++; if (overrun !== 1'b1)  begin errors++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    endtask

    task automatic test_full_push_pop();
        fill16(8'h10);
        rx_valid = 1'b1; rx_data = 8'h55; rd_ready = 1'b1;
        tick();
        rx_valid = 1'b0; rx_data = 8'h00; rd_ready = 1'b0;
        checks++; if (level !== 5'd16)   begin errors++; $display("FAIL fpp_level got=%0d exp=16", level); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL fpp_overrun got=%0b exp=0", overrun); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fpp_head got=%h exp=11", rd_data); end
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (rd_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, rd_data, 8'h10 + 8'(i));
            end
            tick();
        end
        checks++; if (rd_data !== 8'h55 || level !== 5'd1) begin
            errors++; $display("FAIL fpp_last got=%h lvl=%0d exp=55 lvl=1", rd_data, level);
        end
        tick();
        rd_ready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL fpp_empty got=%0d exp=0", level); end
        fill16(8'h00);
        rx_valid = 1'b1; rx_data = 8'hEE; overrun_clr = 1'b1;
        tick();
        rx_valid = 1'b0; overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fpp_set_wins got=%0b exp=1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fpp_clr_alone got=%0b exp=0", overrun); end
        do_flush();
    endtask

    task automatic test_thresh();
        thresh = 5'd4;
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b0);
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_below got=%0b exp=0", irq_thresh); end
        push_byte(8'h04, 1'b0);
        checks++; if (irq_thresh !== 1'b1 || level !== 5'd4) begin
            errors++; $display("FAIL thr_reach got=%0b lvl=%0d exp=1 lvl=4", irq_thresh, level);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (irq_thresh !== 1'b0 || level !== 5'd3) begin
            errors++; $display("FAIL thr_fall got=%0b lvl=%0d exp=0 lvl=3", irq_thresh, level);
        end
        thresh = 5'd3;
        #1;
        checks++; if (irq_thresh !== 1'b1) begin errors++; $display("FAIL thr_eq3 got=%0b exp=1", irq_thresh); end
        thresh = 5'd0;
        #1;
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_disabled got=%0b exp=0", irq_thresh); end
        do_flush();
        fill16(8'h00);
        thresh = 5'd17;
        #1;
        checks++; if (irq_thresh !== 1'b0) begin errors++; $display("FAIL thr_above_depth got=%0b exp=0", irq_thresh); end
        thresh = 5'd0;
        do_flush();
    endtask

    task automatic test_break();
        push_byte(8'h31, 1'b0);
        push_byte(8'h00, 1'b1);
        push_byte(8'h32, 1'b0);
        checks++; if (rd_data !== 8'h31 || rd_break !== 1'b0) begin
            errors++; $display("FAIL brk_head0 got=%h/%0b exp=31/0", rd_data, rd_break);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        checks++; if (rd_data !== 8'h00 || rd_break !== 1'b1) begin
            errors++; $display("FAIL brk_head1 got=%h/%0b exp=00/1", rd_data, rd_break);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        checks++; if (rd_data !== 8'h32 || rd_break !== 1'b0) begin
            errors++; $display("FAIL brk_head2 got=%h/%0b exp=32/0", rd_data, rd_break);
        end
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rd_break !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL brk_empty got=%0b/%0b/%h exp=0/0/00", rd_valid, rd_break, rd_data);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 1'b0);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL fl_pre_level got=%0d exp=5", level); end
        flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        flush = 1'b0; rx_valid = 1'b0;
        checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL fl_mid got=%0d/%0b exp=0/0", level, rd_valid);
        end
        fill16(8'h00);
        flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h78;
        tick();
        flush = 1'b0; rx_valid = 1'b0;
        checks++; if (overrun !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL fl_full_no_ovr got=%0b/%0d exp=0/0", overrun, level);
        end
        fill16(8'h00);
        push_byte(8'hAB, 1'b0);
        do_flush();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL fl_keeps_ovr got=%0b exp=1", overrun); end
    endtask

    task automatic test_async_reset();
        fill16(8'h20);
        push_byte(8'hCD, 1'b0);
        rx_valid = 1'b1; rx_data = 8'h99;
        #2 resetn = 1'b0;
        #1;
        checks++; if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL arst_ptrs got=%0d/%0b/%0b exp=0/0/0", level, rd_valid, full);
        end
        checks++; if (overrun !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL arst_flags got=%0b/%h exp=0/00", overrun, rd_data);
        end
        #1;
        rx_valid = 1'b0;
        resetn = 1'b1;
        tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL arst_after got=%0d exp=0", level); end
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
        flush = 1'b0; rd_ready = 1'b0; thresh = 5'd0; overrun_clr = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_thresh();
        test_break();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver.
- Captures each single-cycle received-byte pulse, together with its BREAK flag, into a DEPTH-entry circular buffer.
- Presents the head entry to the CPU/peripheral bus through a valid/ready read port.
- Provides fill level, a programmable threshold interrupt and a sticky overrun flag, so software can poll or take interrupts instead of catching one-cycle pulses.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- LVL_W, $clog2(DEPTH)+1, width of the level and threshold fields (derived, not overridden).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx_valid  in  1  single-cycle pulse: received byte available from the UART receiver
- rx_data  in  8  received byte, qualified by rx_valid
- rx_break  in  1  BREAK indication, qualified by rx_valid
- flush  in  1  synchronous clear of the FIFO contents
- rd_ready  in  1  consumer pops the head entry when rd_valid && rd_ready
- rd_valid  out  1  FIFO non-empty; head entry presented
- rd_data  out  8  head byte
- rd_break  out  1  head entry was a BREAK
- level  out  LVL_W  current number of stored entries, 0..DEPTH
- thresh  in  LVL_W  interrupt threshold; 0 disables the interrupt
- irq_thresh  out  1  level >= thresh and thresh != 0
- full  out  1  level == DEPTH
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (resetn low, asynchronous): pointers = 0, level = 0, overrun = 0. Outputs: rd_valid = 0, full = 0, irq_thresh = 0. rd_data and rd_break read as 0 while empty. Storage array is not reset.
- Storage entries are 9 bits: {break, data}.
- Pointers: LVL_W-bit read and write pointers (index bits plus a wrap bit).
  - Empty: pointers equal.
  - Full: indices equal and wrap bits differ.
  - level = wptr - rptr, modulo 2^LVL_W.
- Push: when rx_valid && (!full || pop) && !flush, write the entry at wptr and increment wptr, with natural wrap-around.
- Pop: when rd_valid && rd_ready && !flush, increment rptr.
- Latency and read path:
  - Show-ahead: rd_data and rd_break are driven combinationally from mem[rptr index], gated to 0 when empty.
  - A byte pushed at edge N is visible with rd_valid = 1 after edge N, i.e. push-to-read latency is one cycle.
- Simultaneous push and pop when full: both happen; level stays DEPTH; overrun is not set.
- Simultaneous push and pop at level 1: both happen; level stays 1; the new byte becomes head.
- Push when empty: no same-cycle bypass, because rd_valid is still 0.
- Overrun: rx_valid && full && !pop && !flush
  - The byte is discarded; storage and pointers are unchanged.
  - overrun is set at the next edge.
  - If overrun_clr is asserted in the same cycle, set wins.
  - overrun_clr alone clears overrun at the next edge.
- Flush: both pointers go to 0 at the next edge; level becomes 0.
  - A push or pop in the same cycle is ignored, and an ignored push does not set overrun.
  - overrun is unaffected by flush.
- irq_thresh and full are registered-equivalent: derived combinationally from the registered pointers and thresh, with no path from rx_valid or rd_ready. thresh > DEPTH means irq_thresh never asserts.
- No state machine beyond the pointer/flag registers; all state updates are on the rising edge of clk except reset.

Decomposition:
- Shared UART package holds:
  - UART_PAYLOAD_BITS = 8 (shared with the receiver);
  - UART_FIFO_ENTRY_W = 9;
  - the {break, data} entry field offsets.
- One natural sub-module: uart_fifo_mem, a DEPTH x 9 register array with one write port and one asynchronous read port. It is reusable for a TX FIFO. Pointer, level and flag logic stay in uart_rx_fifo.

Test Plan:
- After reset: push 0x41, 0x42, 0x43 on separate pulses; rd_ready = 0. Expect level = 3, rd_data = 0x41, rd_valid = 1 one cycle after the first pulse. Then hold rd_ready = 1: expect pops of 0x41, 0x42, 0x43 in order, then rd_valid = 0 and level = 0.
- Fill DEPTH = 16 entries 0x00..0x0F, then push 0xAA with rd_ready = 0. Expect full = 1, level = 16, overrun = 1. The next pops return 0x00..0x0F; 0xAA never appears.
- With the FIFO full, assert rx_valid (0x55) and rd_ready in the same cycle. Expect level to stay 16, overrun = 0, and 0x55 to be read last after 15 further pops. Separately, assert overrun_clr together with a new overrun event: expect overrun to stay 1.
- Set thresh = 4 and push 4 bytes: irq_thresh rises the cycle level reaches 4. Pop 1: irq_thresh falls. Set thresh = 0: irq_thresh = 0 at any level.
- Push a BREAK (rx_break = 1, rx_data = 0x00) between 0x31 and 0x32. Expect rd_break = 1 only while the second entry is at the head.
- Mid-stream: with level = 5, assert flush together with rx_valid = 1. Expect level = 0, rd_valid = 0, overrun unchanged. Also assert resetn low asynchronously mid-push: outputs go to their reset values immediately, without a clock edge.
